// File: rtl/draw_circles_multi.sv
// N-channel circle overlay stage: frame-latched centres, 3-cycle pipeline,
// lowest channel index wins where circles overlap.
`timescale 1ns/1ps
module draw_circles_multi #(
  parameter int                     N_CIRCLES = 2,
  parameter logic [8*N_CIRCLES-1:0]  RADII     = {8'd10, 8'd20},
  parameter logic [12*N_CIRCLES-1:0] COLORS    = {12'habc, 12'hf00},
  parameter int                     RING      = 0
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [11:0]             hcount_in,
  input  logic [11:0]             vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    hblnk_in,
  input  logic                    vblnk_in,
  input  logic [11:0]             rgb_in,
  input  logic [12*N_CIRCLES-1:0] xpos_in,
  input  logic [12*N_CIRCLES-1:0] ypos_in,
  input  logic [N_CIRCLES-1:0]    en_in,
  output logic [11:0]             hcount_out,
  output logic [11:0]             vcount_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    hblnk_out,
  output logic                    vblnk_out,
  output logic [11:0]             rgb_out,
  output logic [N_CIRCLES-1:0]    hit_out,
  output logic [12*N_CIRCLES-1:0] xpos_out,
  output logic [12*N_CIRCLES-1:0] ypos_out
);

  localparam int TW = 40;

  logic                    vblnk_prev;
  logic [12*N_CIRCLES-1:0] xs, ys;
  logic [N_CIRCLES-1:0]    ens, en1, en2, in_c;
  logic [TW-1:0]           tim1, tim2;
  logic [11:0]             rgb_c;
  logic                    found;

  assign xpos_out = xs;
  assign ypos_out = ys;

  // Shadow centres/enables change only on the vblank rising edge.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      vblnk_prev <= 1'b0;
      xs         <= '0;
      ys         <= '0;
      ens        <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        xs  <= xpos_in;
        ys  <= ypos_in;
        ens <= en_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tim1 <= '0;
      tim2 <= '0;
      en1  <= '0;
      en2  <= '0;
    end else begin
      tim1 <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
      tim2 <= tim1;
      en1  <= ens;
      en2  <= en1;
    end
  end

  for (genvar g = 0; g < N_CIRCLES; g++) begin : g_ch
    localparam int          R       = int'(RADII[8*g +: 8]);
    localparam logic [24:0] R2      = 25'(R * R);
    localparam bit          RING_ON = (RING > 0) && (R > RING);
    localparam logic [24:0] RI2     = RING_ON ? 25'((R - RING) * (R - RING)) : '0;

    logic signed [12:0] dx, dy;
    logic signed [25:0] sqx, sqy;
    logic [24:0]        d2;

    // 13-bit signed differences keep far-off centres from wrapping into view.
    assign sqx = 26'(dx) * 26'(dx);
    assign sqy = 26'(dy) * 26'(dy);

    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        dx <= '0;
        dy <= '0;
        d2 <= '0;
      end else begin
        dx <= $signed({1'b0, hcount_in}) - $signed({1'b0, xs[12*g +: 12]});
        dy <= $signed({1'b0, vcount_in}) - $signed({1'b0, ys[12*g +: 12]});
        d2 <= 25'(sqx + sqy);
      end
    end

    assign in_c[g] = en2[g] && (d2 <= R2) && (!RING_ON || (d2 > RI2));
  end

  always_comb begin
    rgb_c = tim2[11:0];
    found = 1'b0;
    for (int unsigned i = 0; i < N_CIRCLES; i++) begin
      if (in_c[i] && !found) begin
        rgb_c = COLORS[12*i +: 12];
        found = 1'b1;
      end
    end
    if (tim2[13] || tim2[12]) rgb_c = '0;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      hit_out    <= '0;
    end else begin
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= tim2[39:12];
      rgb_out <= rgb_c;
      hit_out <= in_c;
    end
  end

endmodule
